// File: rtl/filt_sched_pkg.sv
// Shared types, defaults and width helpers for the pulse-shaping filter sequencer.
package filt_sched_pkg;

  typedef enum logic [1:0] {BOOT, LOAD, FLUSH, RUN} state_e;

  localparam int DEF_WIDTH     = 18;
  localparam int DEF_LENGTH    = 93;
  localparam int DEF_NUM_BANKS = 8;
  localparam int DEF_SAM_DIV   = 4;
  localparam int DEF_SYM_DIV   = 4;

  // Symmetric filter: only the centre tap plus one half is stored.
  function automatic int taps_of(input int length);
    return (length + 1) / 2;
  endfunction

  function automatic int bits_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w_of(input int num_banks, input int length);
    return bits_of(num_banks * taps_of(length));
  endfunction

endpackage

// File: rtl/filt_sched_if.sv
// Bundle between the sequencer, its coefficient ROM, the LUT and the filter datapath.
interface filt_sched_if
  import filt_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LENGTH    = DEF_LENGTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int SYM_DIV   = DEF_SYM_DIV
);
  localparam int ADDR_W = addr_w_of(NUM_BANKS, LENGTH);
  localparam int BANK_W = bits_of(NUM_BANKS);
  localparam int TAP_W  = bits_of(taps_of(LENGTH));
  localparam int PH_W   = bits_of(SYM_DIV);

  logic              load_req;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              lut_we;
  logic [BANK_W-1:0] lut_bank;
  logic [TAP_W-1:0]  lut_tap;
  logic [WIDTH-1:0]  lut_data;
  logic              filt_reset;
  logic              sam_clk_en;
  logic              sym_clk_en;
  logic [PH_W-1:0]   sym_phase;
  logic              y_valid;

  modport master (
    input  load_req, rom_data,
    output load_busy, load_done, rom_addr, lut_we, lut_bank, lut_tap, lut_data,
           filt_reset, sam_clk_en, sym_clk_en, sym_phase, y_valid
  );

  modport slave (
    output load_req, rom_data,
    input  load_busy, load_done, rom_addr, lut_we, lut_bank, lut_tap, lut_data,
           filt_reset, sam_clk_en, sym_clk_en, sym_phase, y_valid
  );

endinterface

// File: rtl/filt_sched_clk_en_gen.sv
// Sample / symbol clock-enable generator; counters are held at zero while run_i is low.
module filt_sched_clk_en_gen
  import filt_sched_pkg::*;
#(
  parameter int SAM_DIV = DEF_SAM_DIV,
  parameter int SYM_DIV = DEF_SYM_DIV
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_i,
  output logic                       sam_clk_en_o,
  output logic                       sym_clk_en_o,
  output logic [bits_of(SYM_DIV)-1:0] sym_phase_o
);
  localparam int DIV_W = bits_of(SAM_DIV);
  localparam int PH_W  = bits_of(SYM_DIV);

  logic [DIV_W-1:0] div_cnt_q;
  logic [PH_W-1:0]  next_ph_q;
  logic [PH_W-1:0]  sym_phase_q;
  logic             sam_en_q;
  logic             sym_en_q;

  // sym_phase_q reports the index of the most recent sample pulse, so it
  // reads 0 on the same cycle as sym_clk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      next_ph_q   <= '0;
      sym_phase_q <= '0;
      sam_en_q    <= 1'b0;
      sym_en_q    <= 1'b0;
    end else if (!run_i) begin
      div_cnt_q   <= '0;
      next_ph_q   <= '0;
      sym_phase_q <= '0;
      sam_en_q    <= 1'b0;
      sym_en_q    <= 1'b0;
    end else begin
      sam_en_q <= 1'b0;
      sym_en_q <= 1'b0;
      if (div_cnt_q == DIV_W'(SAM_DIV - 1)) begin
        div_cnt_q   <= '0;
        sam_en_q    <= 1'b1;
        sym_en_q    <= (next_ph_q == '0);
        sym_phase_q <= next_ph_q;
        next_ph_q   <= (next_ph_q == PH_W'(SYM_DIV - 1)) ? '0 : next_ph_q + 1'b1;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  assign sam_clk_en_o = sam_en_q;
  assign sym_clk_en_o = sym_en_q;
  assign sym_phase_o  = sym_phase_q;

endmodule

// File: rtl/filt_sched.sv
// Filter sequencer: loads the mapper LUT from ROM, then flushes the delay line and runs.
module filt_sched
  import filt_sched_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LENGTH    = DEF_LENGTH,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int SAM_DIV   = DEF_SAM_DIV,
  parameter int SYM_DIV   = DEF_SYM_DIV
) (
  input  logic         sys_clk,
  input  logic         reset,
  filt_sched_if.master bus
);
  localparam int TAPS   = taps_of(LENGTH);
  localparam int ADDR_W = addr_w_of(NUM_BANKS, LENGTH);
  localparam int BANK_W = bits_of(NUM_BANKS);
  localparam int TAP_W  = bits_of(TAPS);
  localparam int PH_W   = bits_of(SYM_DIV);
  localparam int FL_W   = bits_of(LENGTH);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BANK_W-1:0] bank_q;
  logic [TAP_W-1:0]  tap_q;
  logic              addr_done_q;
  logic [FL_W-1:0]   flush_cnt_q;
  logic              lut_we_q;
  logic [BANK_W-1:0] lut_bank_q;
  logic [TAP_W-1:0]  lut_tap_q;
  logic [WIDTH-1:0]  lut_data_q;
  logic              load_done_q;
  logic              load_busy_q;
  logic              filt_reset_q;
  logic              y_valid_q;

  logic              active;
  logic              go_load;
  logic              run;
  logic              sam_en;
  logic              sym_en;
  logic [PH_W-1:0]   sym_phase;

  assign active  = (state_q == FLUSH) || (state_q == RUN);
  assign go_load = (state_q == BOOT) || (active && bus.load_req);
  // A reload request clears the enables on the same edge the FSM enters LOAD.
  assign run     = active && !bus.load_req;

  filt_sched_clk_en_gen #(
    .SAM_DIV (SAM_DIV),
    .SYM_DIV (SYM_DIV)
  ) u_clk_en (
    .clk          (sys_clk),
    .rst          (reset),
    .run_i        (run),
    .sam_clk_en_o (sam_en),
    .sym_clk_en_o (sym_en),
    .sym_phase_o  (sym_phase)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      addr_q       <= '0;
      bank_q       <= '0;
      tap_q        <= '0;
      addr_done_q  <= 1'b0;
      flush_cnt_q  <= '0;
      lut_we_q     <= 1'b0;
      lut_bank_q   <= '0;
      lut_tap_q    <= '0;
      lut_data_q   <= '0;
      load_done_q  <= 1'b0;
      load_busy_q  <= 1'b0;
      filt_reset_q <= 1'b1;
      y_valid_q    <= 1'b0;
    end else begin
      lut_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      if (go_load) begin
        state_q      <= LOAD;
        addr_q       <= '0;
        bank_q       <= '0;
        tap_q        <= '0;
        addr_done_q  <= 1'b0;
        flush_cnt_q  <= '0;
        load_busy_q  <= 1'b1;
        filt_reset_q <= 1'b1;
        y_valid_q    <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            // Write stage: ROM data for addr_q is captured alongside its bank/tap.
            if (!addr_done_q) begin
              lut_we_q   <= 1'b1;
              lut_bank_q <= bank_q;
              lut_tap_q  <= tap_q;
              lut_data_q <= bus.rom_data;
              if (tap_q == TAP_W'(TAPS - 1)) begin
                tap_q <= '0;
                if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
                  addr_done_q <= 1'b1;
                  load_done_q <= 1'b1;
                end else begin
                  bank_q <= bank_q + 1'b1;
                  addr_q <= addr_q + 1'b1;
                end
              end else begin
                tap_q  <= tap_q + 1'b1;
                addr_q <= addr_q + 1'b1;
              end
            end else begin
              state_q      <= FLUSH;
              addr_q       <= '0;
              bank_q       <= '0;
              addr_done_q  <= 1'b0;
              load_busy_q  <= 1'b0;
              filt_reset_q <= 1'b0;
            end
          end
          FLUSH: begin
            if (sam_en) begin
              if (flush_cnt_q == FL_W'(LENGTH - 1)) begin
                state_q   <= RUN;
                y_valid_q <= 1'b1;
              end else begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
              end
            end
          end
          RUN:     state_q <= RUN;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  assign bus.load_busy  = load_busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.rom_addr   = addr_q;
  assign bus.lut_we     = lut_we_q;
  assign bus.lut_bank   = lut_bank_q;
  assign bus.lut_tap    = lut_tap_q;
  assign bus.lut_data   = lut_data_q;
  assign bus.filt_reset = filt_reset_q;
  assign bus.sam_clk_en = sam_en;
  assign bus.sym_clk_en = sym_en;
  assign bus.sym_phase  = sym_phase;
  assign bus.y_valid    = y_valid_q;

endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched: timeline-based reference model driven by randomized load requests.
module tb_filt_sched;
  localparam int WIDTH     = 18;
  localparam int LENGTH    = 93;
  localparam int NUM_BANKS = 8;
  localparam int SAM_DIV   = 4;
  localparam int SYM_DIV   = 4;
  localparam int TAPS      = (LENGTH + 1) / 2;
  localparam int NWR       = NUM_BANKS * TAPS;
  localparam int FLUSH_CYC = LENGTH * SAM_DIV;

  logic             sys_clk = 1'b0;
  logic             reset   = 1'b0;
  logic [WIDTH-1:0] rom_key = '0;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference timeline: m_boot before the first load, m_t = cycle within LOAD,
  // m_u = cycle since FLUSH entry (continues through RUN).
  bit m_boot = 1'b1;
  int m_t    = -1;
  int m_u    = -1;

  int we_cnt, sam_cnt, sym_cnt, sym0_cnt, yv_cnt;

  filt_sched_if #(
    .WIDTH(WIDTH), .LENGTH(LENGTH), .NUM_BANKS(NUM_BANKS), .SYM_DIV(SYM_DIV)
  ) bus ();

  filt_sched #(
    .WIDTH(WIDTH), .LENGTH(LENGTH), .NUM_BANKS(NUM_BANKS),
    .SAM_DIV(SAM_DIV), .SYM_DIV(SYM_DIV)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  assign bus.rom_data = WIDTH'(bus.rom_addr) ^ rom_key;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_t    = -1;
    m_u    = -1;
  endtask

  task automatic model_edge(input bit req);
    if (reset) return;
    if (m_boot) begin
      m_boot = 1'b0;
      m_t    = 0;
    end else if (m_t >= 0) begin
      if (m_t == NWR) begin
        m_t = -1;
        m_u = 0;
      end else m_t++;
    end else if (m_u >= 0) begin
      if (req) begin
        m_t = 0;
        m_u = -1;
      end else m_u++;
    end
  endtask

  task automatic compare_all();
    logic e_busy, e_done, e_frst, e_we, e_sam, e_sym, e_yv;
    int   e_addr, e_ph, s;
    e_busy = 0; e_done = 0; e_frst = 1; e_we = 0;
    e_sam = 0; e_sym = 0; e_yv = 0; e_addr = 0; e_ph = 0;
    if (m_t >= 0) begin
      e_busy = 1;
      e_we   = (m_t >= 1);
      e_done = (m_t == NWR);
      e_addr = (m_t < NWR) ? m_t : NWR - 1;
    end else if (m_u >= 0) begin
      e_frst = 0;
      e_sam  = (m_u >= SAM_DIV) && (m_u % SAM_DIV == 0);
      s      = m_u / SAM_DIV;
      if (s >= 1) e_ph = (s - 1) % SYM_DIV;
      e_sym  = e_sam && (e_ph == 0);
      e_yv   = (m_u > FLUSH_CYC);
    end
    chk("load_busy", bus.load_busy, e_busy);
    chk("load_done", bus.load_done, e_done);
    chk("filt_reset", bus.filt_reset, e_frst);
    chk("lut_we", bus.lut_we, e_we);
    chk("sam_clk_en", bus.sam_clk_en, e_sam);
    chk("sym_clk_en", bus.sym_clk_en, e_sym);
    chk("sym_phase", bus.sym_phase, e_ph);
    chk("y_valid", bus.y_valid, e_yv);
    chk("rom_addr", bus.rom_addr, e_addr);
    if (e_we) begin
      chk("lut_bank", bus.lut_bank, (m_t - 1) / TAPS);
      chk("lut_tap", bus.lut_tap, (m_t - 1) % TAPS);
      chk("lut_data", bus.lut_data, WIDTH'(m_t - 1) ^ rom_key);
    end
    if (bus.lut_we) we_cnt++;
    if (bus.sam_clk_en) sam_cnt++;
    if (bus.sym_clk_en) sym_cnt++;
    if (bus.sym_clk_en && bus.sym_phase == '0) sym0_cnt++;
    if (bus.y_valid) yv_cnt++;
  endtask

  task automatic cyc(input bit req);
    bus.load_req = req;
    @(posedge sys_clk);
    model_edge(req);
    #1;
    bus.load_req = 1'b0;
    compare_all();
  endtask

  task automatic run_load(input bit noisy);
    int g;
    g = 0;
    we_cnt = 0;
    while (m_t >= 0 && g < 1000) begin
      cyc(noisy && ($urandom_range(0, 7) == 0));
      g++;
    end
    chk("load_in_time", (g < 1000), 1);
    chk("write_count", we_cnt, NWR);
  endtask

  task automatic run_flush();
    int g;
    g = 0;
    sam_cnt = 0;
    while (m_u >= 0 && m_u <= FLUSH_CYC && g < 1000) begin
      cyc(1'b0);
      g++;
    end
    chk("flush_sams", sam_cnt, LENGTH);
    chk("y_valid_up", bus.y_valid, 1);
  endtask

  task automatic reload_from_run();
    repeat ($urandom_range(0, 20)) cyc(1'b0);
    rom_key = WIDTH'($urandom);
    cyc(1'b1);
    chk("reload_busy", bus.load_busy, 1);
    chk("reload_frst", bus.filt_reset, 1);
    chk("reload_yv", bus.y_valid, 0);
    chk("reload_en", {bus.sam_clk_en, bus.sym_clk_en}, 2'b00);
  endtask

  initial begin
    int g;
    bit req;
    bus.load_req = 1'b0;
    #1 reset = 1'b1;
    #2 compare_all();
    repeat (2) cyc(1'b0);
    @(negedge sys_clk);
    reset = 1'b0;

    // Boot load with data = addr, then flush into RUN.
    cyc(1'b0);
    run_load(1'b1);
    run_flush();

    // Enable cadence over 64 cycles in RUN.
    sam_cnt = 0; sym_cnt = 0; sym0_cnt = 0;
    repeat (64) cyc(1'b0);
    chk("cadence_sam", sam_cnt, 16);
    chk("cadence_sym", sym_cnt, 4);
    chk("cadence_sym_ph0", sym0_cnt, 4);

    // Reload from RUN; then a request on the last FLUSH cycle.
    reload_from_run();
    run_load(1'b1);
    g = 0;
    while (m_u < FLUSH_CYC && g < 1000) begin
      cyc(1'b0);
      g++;
    end
    chk("last_flush_sam", bus.sam_clk_en, 1);
    rom_key = WIDTH'($urandom);
    cyc(1'b1);
    chk("late_req_busy", bus.load_busy, 1);
    yv_cnt = 0;
    run_load(1'b0);
    chk("late_req_yv", yv_cnt, 0);
    run_flush();

    // Asynchronous reset in the middle of a load.
    reload_from_run();
    g = 0;
    while (m_t < 201 && g < 1000) begin
      cyc(1'b0);
      g++;
    end
    chk("mid_write_200", bus.lut_tap + TAPS * bus.lut_bank, 200);
    #3 reset = 1'b1;
    #1 model_reset();
    compare_all();
    repeat (2) cyc(1'b0);
    @(negedge sys_clk);
    reset = 1'b0;
    cyc(1'b0);
    chk("restart_addr", bus.rom_addr, 0);
    run_load(1'b1);
    run_flush();

    // Random soak with sparse reload requests.
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 299) == 0);
      if (req && m_u >= 0) rom_key = WIDTH'($urandom);
      cyc(req);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
